// File: rtl/uart_tx_result.sv
// uart_tx_result: transmit side of the host UART link.
// Sends a 16-bit result word as two back-to-back 8N1 bytes, low byte first.
// The baud counter and serializer are built in. tx, busy and done are all
// registered so that the serial line stays glitch-free.
module uart_tx_result #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [15:0] tx_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  // A bit period shorter than two clocks cannot hold a registered line value.
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_result: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   baud_cnt, baud_next;
  logic [2:0]         bit_idx, bit_next;
  logic               byte_idx, byte_next;
  logic [7:0]         shift, shift_next;
  logic [15:0]        hold, hold_next;
  logic               tx_next, busy_next, done_next;
  logic               bit_end;

  // The current serial bit has run its full length on this cycle.
  assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // State register: FSM state, datapath and the registered outputs.
  // NOTE: sequential state is assigned with <= so that every register samples
  // the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
      shift    <= '0;
      // NOTE: the holding register is reset too; it is only 16 flops, and a
      // known value keeps simulation free of X after a mid-frame reset.
      hold     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      shift    <= shift_next;
      hold     <= hold_next;
      tx       <= tx_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // Next-state logic: bit timing, byte sequencing and word capture.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    baud_next  = bit_end ? '0 : baud_cnt + CNT_W'(1);
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    shift_next = shift;
    hold_next  = hold;

    unique case (state)
      IDLE: begin
        baud_next = '0;
        // busy is still high in the done cycle, so a trigger there is dropped.
        if (trigger && !busy) begin
          hold_next  = tx_data;
          byte_next  = 1'b0;
          shift_next = tx_data[7:0];
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift >> 1;
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!byte_idx) begin
            // Second byte follows immediately, with no idle gap.
            byte_next  = 1'b1;
            shift_next = hold[15:8];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the values the output registers take on the next edge.
  always_comb begin
    done_next = (state == STOP) && bit_end && byte_idx;
    busy_next = (state_next != IDLE) || done_next;
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_result.sv
// Testbench for uart_tx_result. A behavioural frame model (bit list indexed
// by cycle offset) is compared against both instances on every cycle; a
// handful of hand-computed line patterns and timings pin the model itself.
module tb_uart_tx_result;

  localparam int C0 = 16;   // CLK_FREQ=16, BAUD_RATE=1
  localparam int C1 = 868;  // default parameters

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig   [2];
  logic [15:0] data   [2];
  logic        tx_o   [2];
  logic        busy_o [2];
  logic        done_o [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_result #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk(clk), .reset(rst_n), .trigger(trig[0]), .tx_data(data[0]),
    .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  uart_tx_result dut_def (
    .clk(clk), .reset(rst_n), .trigger(trig[1]), .tx_data(data[1]),
    .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int cpb(input int k);
    return (k == 0) ? C0 : C1;
  endfunction

  // Line levels of one frame in transmit order; index 0 is sent first.
  function automatic logic [19:0] frame_bits(input logic [15:0] d);
    return {1'b1, d[15:8], 1'b0, 1'b1, d[7:0], 1'b0};
  endfunction

  bit          m_active [2];
  int          m_pos    [2];
  logic [19:0] m_bits   [2];

  // Model: a frame is a cycle offset 0..20*C (20*C is the done cycle).
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_active[k] <= 1'b0;
      end else if (m_active[k]) begin
        if (m_pos[k] == 20 * cpb(k)) m_active[k] <= 1'b0;
        else                         m_pos[k]    <= m_pos[k] + 1;
      end else if (trig[k]) begin
        m_active[k] <= 1'b1;
        m_pos[k]    <= 0;
        m_bits[k]   <= frame_bits(data[k]);
      end
    end
  end

  // Compare process: every cycle, both instances, on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        logic e_tx, e_busy, e_done;
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        if (rst_n && m_active[k]) begin
          e_busy = 1'b1;
          e_done = (m_pos[k] == 20 * cpb(k));
          if (m_pos[k] < 20 * cpb(k)) e_tx = m_bits[k][m_pos[k] / cpb(k)];
        end
        check($sformatf("model_tx%0d", k),   tx_o[k],   e_tx);
        check($sformatf("model_busy%0d", k), busy_o[k], e_busy);
        check($sformatf("model_done%0d", k), done_o[k], e_done);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_trigger0(input logic [15:0] d);
    @(posedge clk); #2;
    data[0] = d;
    trig[0] = 1'b1;
    @(posedge clk); #2;
    trig[0] = 1'b0;
  endtask

  task automatic wait_fall0(output bit fell);
    fell = 1'b0;
    for (int i = 0; i < 4 && !fell; i++) begin
      @(negedge clk);
      fell = (tx_o[0] == 1'b0);
    end
    check("tx_fall", fell, 1);
  endtask

  // One frame on instance 0: bit-centre samples, fall-to-done latency and
  // busy one cycle after done. Optionally changes tx_data mid-frame and
  // fires extra triggers at offset 100 and in the done cycle.
  task automatic run_frame(input logic [15:0] d, input logic [15:0] d_late,
                           input bit extra, output logic [0:19] seq,
                           output int lat, output logic busy_after);
    bit fell;
    int c;
    seq = 'x; lat = -1; busy_after = 1'bx;
    pulse_trigger0(d);
    wait_fall0(fell);
    if (!fell) return;
    c = 0;
    while (c <= 20 * C0 + 2) begin
      if (c % C0 == C0 / 2 && c < 20 * C0) seq[c / C0] = tx_o[0];
      if (lat < 0 && done_o[0]) lat = c;
      if (lat >= 0 && c == lat + 1) busy_after = busy_o[0];
      if (c == 40) data[0] = d_late;
      if (extra) trig[0] = (c == 100 || c == lat);
      @(negedge clk);
      c++;
    end
    trig[0] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [0:19] seq;
    logic [0:19] exp_seq;
    int          lat;
    logic        busy_after;
    int          bh;
    bit          fell;
    int          c, first_rise, next_fall;

    rst_n = 1'b0;
    trig[0] = 1'b0; trig[1] = 1'b0;
    data[0] = '0;   data[1] = '0;
    cmp_en = 1'b1;

    // Reset values
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("reset_tx", tx_o[0], 1);
    check("reset_busy", busy_o[0], 0);
    check("reset_done", done_o[0], 0);

    // Basic frame 0x1234
    run_frame(16'h1234, 16'h1234, 1'b0, seq, lat, busy_after);
    exp_seq = 20'b0_00101100_1_0_01001000_1;
    check("basic_seq", seq, exp_seq);
    check("basic_latency", lat, 320);
    check("basic_busy_after", busy_after, 0);

    // Data stability: tx_data changes mid-frame
    run_frame(16'hA55A, 16'hFFFF, 1'b0, seq, lat, busy_after);
    exp_seq = 20'b0_01011010_1_0_10100101_1;
    check("stable_seq", seq, exp_seq);

    // Ignored triggers at offset 100 and in the done cycle
    run_frame(16'h3C96, 16'h3C96, 1'b1, seq, lat, busy_after);
    check("ignore_latency", lat, 320);
    check("ignore_busy_after", busy_after, 0);
    bh = 0;
    repeat (50) begin
      @(negedge clk);
      bh += int'(busy_o[0]);
    end
    check("ignore_busy_stays_low", bh, 0);

    // Reset mid-frame during DATA of byte 1
    pulse_trigger0(16'($urandom));
    wait_fall0(fell);
    repeat (14 * C0 + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx", tx_o[0], 1);
    check("midreset_busy", busy_o[0], 0);
    check("midreset_done", done_o[0], 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run_frame(16'h00FF, 16'h00FF, 1'b0, seq, lat, busy_after);
    exp_seq = 20'b0_11111111_1_0_00000000_1;
    check("after_reset_seq", seq, exp_seq);
    check("after_reset_latency", lat, 320);

    // Randomized traffic: random data, random triggers, data churn
    for (int it = 0; it < 8; it++) begin
      pulse_trigger0(16'($urandom));
      repeat (20 * C0 + $urandom_range(0, 30)) begin
        @(posedge clk); #2;
        trig[0] = ($urandom_range(0, 31) == 0);
        data[0] = 16'($urandom);
      end
      trig[0] = 1'b0;
    end
    repeat (20 * C0 + 10) @(negedge clk);

    // Default parameters with trigger held high
    @(posedge clk); #2;
    data[1] = 16'h0001;
    trig[1] = 1'b1;
    fell = 1'b0;
    for (int i = 0; i < 4 && !fell; i++) begin
      @(negedge clk);
      fell = (tx_o[1] == 1'b0);
    end
    check("def_tx_fall", fell, 1);
    c = 0; first_rise = -1; lat = -1; next_fall = -1;
    while (c < 20 * C1 + 10 && next_fall < 0) begin
      if (first_rise < 0 && tx_o[1]) first_rise = c;
      if (lat < 0 && done_o[1]) lat = c;
      if (lat >= 0 && c > lat && !tx_o[1]) next_fall = c;
      @(negedge clk);
      c++;
    end
    trig[1] = 1'b0;
    check("def_bit_width", first_rise, C1);
    check("def_latency", lat, 20 * C1);
    check("def_gap", next_fall - lat, 2);
    repeat (20 * C1 + 5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: every wait above is bounded, this only guards the whole run.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_result.md
Name: uart_tx_result

Overview:
- Transmit end of the board's UART link: serializes a 16-bit result word back to the host PC as two 8N1 bytes, low byte first.
- Sits beside the UART receive path and rx_control. The ALU result (hex) or its BCD form drives tx_data; a one-cycle trigger from the top level starts a frame.
- Contains its own baud-rate counter and bit serializer, so no external UART core is needed on the transmit side.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer truncation; 868 at defaults), clock cycles per serial bit. Must be >= 2; elaboration fails otherwise.

Ports:
- clk  input  1  system clock, CLK100MHZ domain, rising edge.
- reset  input  1  asynchronous, active-low reset (driven directly from CPU_RESETN).
- trigger  input  1  start request, sampled on rising clk; one-cycle pulse expected.
- tx_data  input  16  word to send; captured on the accepted trigger.
- tx  output  1  serial line to the host (UART_RXD_OUT); idles high.
- busy  output  1  high from the accepted trigger through the done cycle.
- done  output  1  one-cycle pulse when the second stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous), takes effect immediately, including mid-frame:
  - tx=1, busy=0, done=0, state=IDLE.
  - Bit counter, baud counter, byte index and shift register all cleared.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - On trigger=1, latch tx_data into a 16-bit holding register, set byte index=0, load shift register with holding[7:0], go to START.
  - Later changes on tx_data have no effect until the next accepted trigger.
- Latency: tx falls and busy rises on the clock edge that samples trigger=1 in IDLE, i.e. both are registered and visible the cycle after trigger.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first.
  - Shift right after each bit. After bit 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. When it ends:
  - If byte index=0: set byte index=1, load shift register with holding[15:8], go directly to START. No idle gap between bytes.
  - If byte index=1: assert done for one cycle (busy still 1 in that cycle), then go to IDLE. busy drops the following cycle.
- Frame timing: exactly 20*CLKS_PER_BIT cycles from the first tx falling edge to the cycle in which done=1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - Reset to 0 on entry to START from IDLE.
  - Width is $clog2(CLKS_PER_BIT).
- trigger while busy=1, including the done cycle, is ignored: no re-latch, no restart, no queueing.
- trigger held high continuously: a new frame starts on the first IDLE cycle after done, so frames run back-to-back separated by one idle-high cycle.
- All outputs are registered. tx is glitch-free.

Test Plan:
- Use CLK_FREQ=16, BAUD_RATE=1 (CLKS_PER_BIT=16) unless noted.
- Reset values: hold reset=0 for 5 cycles, then release with trigger=0 -> tx=1, busy=0, done=0 for 50 cycles.
- Basic frame: tx_data=16'h1234, 1-cycle trigger -> tx falls next cycle. Sampling at bit centres gives 0,00101100,1,0,01001000,1 (bytes 0x34 then 0x12, LSB first). done pulses exactly 320 cycles after the tx fall; busy=0 one cycle later.
- Data stability: trigger with tx_data=16'hA55A, change tx_data to 16'hFFFF during the frame -> line still carries 0x5A then 0xA5.
- Ignored trigger: pulse trigger at cycle 100 of a frame and again in the done cycle -> exactly one frame; busy falls and stays low.
- Reset mid-frame: assert reset during DATA of byte 1 -> tx=1, busy=0 asynchronously, same cycle. After release, a new trigger with 16'h00FF sends a clean frame 0xFF, 0x00.
- Defaults and continuous trigger: CLK_FREQ=100000000, BAUD_RATE=115200, trigger tied high -> each bit 868 cycles, one idle-high cycle between consecutive 17360-cycle frames.
